// File: rtl/kalman_if.sv
// kalman_if: measurement / estimate bundle for kalman_system.
//   adc_dat_a_i : measurement z, 14-bit two's complement
//   adc_dat_b_i : bit 0 is the sample-valid strobe, bits 13:1 unused
//   x_dat       : filtered state estimate, signed 16-bit
//   x_valid     : one-cycle pulse when x_dat updates
//   busy        : high while an update is in progress
//   dac_dat_o   : x_dat saturated to signed 14-bit
// master = sample source / result sink, slave = the filter.
interface kalman_if;
    logic [13:0] adc_dat_a_i;
    logic [13:0] adc_dat_b_i;
    logic [15:0] x_dat;
    logic        x_valid;
    logic        busy;
    logic [13:0] dac_dat_o;

    modport master (
        output adc_dat_a_i,
        output adc_dat_b_i,
        input  x_dat,
        input  x_valid,
        input  busy,
        input  dac_dat_o
    );

    modport slave (
        input  adc_dat_a_i,
        input  adc_dat_b_i,
        output x_dat,
        output x_valid,
        output busy,
        output dac_dat_o
    );
endinterface

// File: rtl/kalman_system.sv
// kalman_system: scalar fixed-point Kalman filter (random-walk model).
// Per accepted sample: predict covariance, compute gain with a 16-cycle
// restoring divider, update state and covariance, then publish.
// Ports:
//   clk : sample clock, all state updates on rising edge
//   rst : synchronous active-high reset
//   bus : kalman_if.slave (measurement in, estimate / DAC code out)
// Latency: capture edge N -> x_valid visible after edge N+19; IDLE again at N+20.
module kalman_system #(
    parameter int unsigned Q_NOISE = 16,
    parameter int unsigned R_NOISE = 4096,
    parameter int unsigned P_INIT  = 4096
) (
    input logic     clk,
    input logic     rst,
    kalman_if.slave bus
);

    localparam logic [16:0] QN = 17'(Q_NOISE);
    localparam logic [16:0] RN = 17'(R_NOISE);
    localparam logic [15:0] PI = 16'(P_INIT);

    typedef enum logic [2:0] {IDLE, PRED, DIV, UPD, OUT} state_t;

    state_t             state_q, state_d;
    logic signed [15:0] z_q;
    logic signed [15:0] x_q;
    logic        [15:0] p_q;
    logic        [15:0] pp_q;
    logic        [16:0] den_q;
    logic        [16:0] rem_q;
    logic        [15:0] k_q;
    logic        [3:0]  cnt_q;
    logic signed [15:0] xn_q;
    logic        [15:0] pn_q;
    logic               x_valid_q;
    logic        [13:0] dac_q;

    // Prediction: Pp = min(P + Q, 65535)
    logic [16:0] pp_sum;
    logic [15:0] pp;
    always_comb begin
        pp_sum = {1'b0, p_q} + QN;
        pp     = pp_sum[16] ? 16'hFFFF : pp_sum[15:0];
    end

    // One restoring-division step. rem_q < den_q always holds, so the
    // shifted remainder fits 18 bits and the kept remainder fits 17.
    logic [17:0] rem_sh;
    logic [17:0] rem_sub;
    logic        rem_ge;
    always_comb begin
        rem_sh  = {rem_q, 1'b0};
        rem_sub = rem_sh - {1'b0, den_q};
        rem_ge  = rem_sh >= {1'b0, den_q};
    end

    // Update: x' = sat16(x + ((K*d) >>> 16)), P' = Pp - floor(K*Pp / 2^16).
    // Taking the top bits of the signed product is the floor shift.
    logic signed [16:0] d;
    logic signed [33:0] kd;
    logic signed [17:0] corr;
    logic signed [18:0] xs;
    logic signed [15:0] xn;
    logic        [31:0] kp;
    logic        [15:0] pn;
    always_comb begin
        d    = {z_q[15], z_q} - {x_q[15], x_q};
        kd   = 34'($signed({1'b0, k_q})) * 34'(d);
        corr = kd[33:16];
        xs   = {{3{x_q[15]}}, x_q} + {corr[17], corr};
        if (xs > 19'sd32767) begin
            xn = 16'sh7FFF;
        end else if (xs < -19'sd32768) begin
            xn = 16'sh8000;
        end else begin
            xn = xs[15:0];
        end
        kp = k_q * pp_q;
        pn = pp_q - kp[31:16];
    end

    // DAC code: estimate clamped to [-8192, 8191]
    logic [13:0] dac_sat;
    always_comb begin
        if (xn_q > 16'sd8191) begin
            dac_sat = 14'h1FFF;
        end else if (xn_q < -16'sd8192) begin
            dac_sat = 14'h2000;
        end else begin
            dac_sat = xn_q[13:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.adc_dat_b_i[0]) state_d = PRED;
            PRED:    state_d = DIV;
            DIV:     if (cnt_q == 4'd15) state_d = UPD;
            UPD:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q       <= '0;
            x_q       <= '0;
            p_q       <= PI;
            pp_q      <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            xn_q      <= '0;
            pn_q      <= '0;
            x_valid_q <= 1'b0;
            dac_q     <= '0;
        end else begin
            x_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.adc_dat_b_i[0]) begin
                        z_q <= {{2{bus.adc_dat_a_i[13]}}, bus.adc_dat_a_i};
                    end
                end
                PRED: begin
                    pp_q  <= pp;
                    den_q <= {1'b0, pp} + RN;
                    rem_q <= {1'b0, pp};
                    k_q   <= '0;
                    cnt_q <= '0;
                end
                DIV: begin
                    rem_q <= rem_ge ? rem_sub[16:0] : rem_sh[16:0];
                    k_q   <= {k_q[14:0], rem_ge};
                    cnt_q <= cnt_q + 4'd1;
                end
                UPD: begin
                    xn_q <= xn;
                    pn_q <= pn;
                end
                OUT: begin
                    x_q       <= xn_q;
                    p_q       <= pn_q;
                    dac_q     <= dac_sat;
                    x_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.x_dat     = x_q;
    assign bus.x_valid   = x_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dac_dat_o = dac_q;

    logic unused_bits;
    assign unused_bits = ^{bus.adc_dat_b_i[13:1], kd[15:0], kp[15:0], rem_sub[17]};

endmodule

// File: tb/tb_kalman_system.sv
module tb_kalman_system;

    localparam int Q = 16;
    localparam int R = 4096;
    localparam int PI = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kalman_if bus ();

    kalman_system #(
        .Q_NOISE (Q),
        .R_NOISE (R),
        .P_INIT  (PI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int x;
        int dac;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    longint mx, mp;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0;
        mp = PI;
    endtask

    // Reference filter step in plain integer arithmetic.
    task automatic model_step(input int z, output int xo, output int dac);
        longint pp, k, dd, sh, xn, pn;
        pp = mp + Q;
        if (pp > 65535) pp = 65535;
        k = (pp * 65536) / (pp + R);
        if (k > 65535) k = 65535;
        dd = longint'(z) - mx;
        sh = (k * dd) >>> 16;
        xn = mx + sh;
        if (xn > 32767) xn = 32767;
        if (xn < -32768) xn = -32768;
        pn = pp - ((k * pp) >> 16);
        mx = xn;
        mp = pn;
        xo = int'(xn);
        dac = (xn > 8191) ? 8191 : (xn < -8192) ? -8192 : int'(xn);
    endtask

    // Called at a negedge while strobe is being driven with z.
    task automatic expect_capture(input int z);
        exp_t e;
        model_step(z, e.x, e.dac);
        e.due = cyc + 1 + 19;
        sb.push_back(e);
    endtask

    task automatic send(input int z);
        @(negedge clk);
        bus.adc_dat_a_i = 14'(z);
        bus.adc_dat_b_i = 14'h0001;
        if (!bus.busy && !rst) expect_capture(z);
        @(negedge clk);
        bus.adc_dat_b_i = 14'h0000;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        chk("result_timeout", sb.size(), 0);
        if (sb.size() > 0) sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.adc_dat_b_i = 14'h0000;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Output monitor: pops the scoreboard on each x_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                chk("missed_x_valid", cyc, e.due);
            end
            if (bus.x_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_x_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("x_valid_cycle", cyc, e.due);
                    chk("x_dat", $signed(bus.x_dat), e.x);
                    chk("dac_dat_o", $signed(bus.dac_dat_o), e.dac);
                end
            end
        end
    end

    initial begin
        int prev, last_cap, cap, z;
        bit have_last, just_cap;

        bus.adc_dat_a_i = '0;
        bus.adc_dat_b_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_x_dat", $signed(bus.x_dat), 0);
        chk("rst_dac", $signed(bus.dac_dat_o), 0);
        chk("rst_x_valid", {31'b0, bus.x_valid}, 0);
        chk("rst_busy", {31'b0, bus.busy}, 0);

        // First sample of 291 from reset
        send(291);
        chk("busy_during_update", {31'b0, bus.busy}, 1);
        wait_idle();
        chk("first_291", $signed(bus.x_dat), 145);
        chk("first_291_dac", $signed(bus.dac_dat_o), 145);
        repeat (6) @(negedge clk);
        chk("hold_x_dat", $signed(bus.x_dat), 145);

        // Second sample and convergence
        send(291);
        wait_idle();
        chk("second_291", $signed(bus.x_dat), 193);
        prev = 193;
        for (int i = 0; i < 4; i++) begin
            send(291);
            wait_idle();
            chk("monotonic", {31'b0, ($signed(bus.x_dat) > prev && $signed(bus.x_dat) <= 291)}, 1);
            prev = $signed(bus.x_dat);
        end

        // Most negative input
        do_reset();
        send(-8192);
        wait_idle();
        chk("neg_x_dat", {16'b0, bus.x_dat}, 32'hEFF8);
        chk("neg_dac", $signed(bus.dac_dat_o), -4104);

        // Continuous strobe with a changing sample every cycle
        have_last = 1'b0;
        just_cap  = 1'b0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            if (just_cap) chk("busy_after_capture", {31'b0, bus.busy}, 1);
            just_cap = 1'b0;
            z = i * 37 - 1000;
            bus.adc_dat_a_i = 14'(z);
            bus.adc_dat_b_i = 14'h0001;
            if (!bus.busy) begin
                cap = cyc + 1;
                if (have_last) chk("capture_spacing", cap - last_cap, 20);
                expect_capture(z);
                last_cap  = cap;
                have_last = 1'b1;
                just_cap  = 1'b1;
            end
        end
        @(negedge clk);
        bus.adc_dat_b_i = 14'h0000;
        wait_idle();

        // Reset in the middle of the division
        do_reset();
        send(291);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_x_dat", $signed(bus.x_dat), 0);
        chk("abort_busy", {31'b0, bus.busy}, 0);
        send(291);
        wait_idle();
        chk("after_abort_291", $signed(bus.x_dat), 145);

        // Strobe coincident with reset is ignored
        @(negedge clk);
        rst = 1'b1;
        bus.adc_dat_a_i = 14'd500;
        bus.adc_dat_b_i = 14'h0001;
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.adc_dat_b_i = 14'h0000;
        chk("strobe_in_rst_busy", {31'b0, bus.busy}, 0);
        repeat (25) @(negedge clk);
        chk("strobe_in_rst_x_dat", $signed(bus.x_dat), 0);

        // Large alternating inputs
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send((i % 2 == 0) ? 8191 : -8192);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kalman_system.md
KALMAN_SYSTEM -- requirements
Module: kalman_system

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every register SHALL update only on the rising edge of clk.
REQ-002 Parameter Q_NOISE, default 16, meaning process-noise variance added to P each step (unsigned 16-bit).
REQ-003 Parameter R_NOISE, default 4096, meaning measurement-noise variance (unsigned 16-bit, nonzero).
REQ-004 Parameter P_INIT, default 4096, meaning error covariance loaded at reset (unsigned 16-bit).
REQ-005 Port clk, input, 1, meaning system clock (ADC sample clock).
REQ-006 Port rst, input, 1, meaning synchronous active-high reset.
REQ-007 Port adc_dat_a_i, input, 14, meaning measurement z, two's complement.
REQ-008 Port adc_dat_b_i, input, 14, meaning bit 0 is sample-valid strobe; bits 13:1 are ignored.
REQ-009 Port x_dat, output, 16, meaning filtered state estimate, signed.
REQ-010 Port x_valid, output, 1, meaning one-cycle pulse when x_dat is updated.
REQ-011 Port busy, output, 1, meaning high while an update is in progress.
REQ-012 Port dac_dat_o, output, 14, meaning x_dat saturated to signed 14-bit range [-8192, 8191].

Function
REQ-013 The FSM SHALL have states IDLE, PRED, DIV, UPD and OUT; busy SHALL be 1 in every state except IDLE.
REQ-014 In IDLE with adc_dat_b_i[0]=1, the block SHALL capture z = sign-extended adc_dat_a_i (edge N) and go to PRED.
REQ-015 PRED (1 cycle) SHALL compute Pp = min(P + Q_NOISE, 65535).
REQ-016 DIV SHALL use a 16-iteration restoring divider (one quotient bit per cycle) to compute K = min(floor(Pp*65536/(Pp+R_NOISE)), 65535), unsigned Q0.16, with a 17-bit denominator.
REQ-017 UPD (1 cycle) SHALL compute d = z - x (17-bit signed) and x' = x + ((K*d) >>> 16), using an arithmetic shift (floor), saturated to signed 16-bit.
REQ-018 UPD SHALL also compute P' = Pp - floor(K*Pp/65536).
REQ-019 OUT SHALL register x_dat=x', x=x', P=P' and dac_dat_o, pulse x_valid for exactly 1 cycle, and return to IDLE.
REQ-020 x_dat and x_valid SHALL become visible exactly 19 clock edges after the capture edge N; the next capture SHALL be possible no earlier than edge N+20.
REQ-021 Strobes arriving while busy=1 SHALL be ignored, and the corresponding samples dropped.
REQ-022 x_dat and dac_dat_o SHALL hold their values between updates.

Reset
REQ-023 rst=1 SHALL, at the next edge, set x=0, P=P_INIT, x_dat=0, dac_dat_o=0, x_valid=0, busy=0, clear the divider, and put the FSM in IDLE.
REQ-024 rst SHALL take priority over every other event, including an assertion mid-update; an aborted update SHALL produce no x_valid pulse.
REQ-025 A strobe present in the same cycle as rst SHALL be ignored.

Verification
REQ-026 Reset, then z=0x123 (291) with strobe for 1 cycle -> x_valid pulses 19 edges later with x_dat=145; internal P=2053, K=32831.
REQ-027 Continuing from REQ-026, a second z=291 -> x_dat=193 (K=21994); repeated samples converge monotonically toward 291 without overshoot.
REQ-028 Reset, then z=0x2000 (-8192) -> x_dat=-4104 (0xEFF8) and dac_dat_o=-4104.
REQ-029 Strobe held high continuously -> x_valid pulses exactly every 20 cycles, busy is low only in the capture cycles, and intermediate samples are ignored.
REQ-030 rst asserted during DIV, then released -> no x_valid pulse, x_dat=0, and the next sample of 291 gives x_dat=145 again.
REQ-031 Large alternating inputs (+8191/-8192) -> x_dat never wraps and dac_dat_o stays within [-8192, 8191].
